// File: rtl/oled_scan_sequencer.sv
// Raster scan of the OLED panel: steps (x,y) per sample strobe, registers returned RGB565 for the driver.
// Optional SCAN_BLINK_EN: blanks white pixels while blink_phase=1 so title text flashes.
module oled_scan_sequencer #(
   parameter int WIDTH        = 96,
   parameter int HEIGHT       = 64,
   parameter int FRAME_CNT_W  = 8,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_begin,
   input  logic                   sample_pixel,
   input  logic [15:0]            screen_data,
   output logic [6:0]             x,
   output logic [5:0]             y,
   output logic [15:0]            pixel_data,
   output logic                   pixel_valid,
   output logic                   frame_done,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic                   blink_phase,
   output logic                   sync_lost
);

   localparam logic [6:0]             X_LAST  = 7'(WIDTH - 1);
   localparam logic [5:0]             Y_LAST  = 6'(HEIGHT - 1);
   localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);

   generate
      if (BLINK_FRAMES < 1) begin : g_bad_blink
         $error("BLINK_FRAMES must be at least 1");
      end
   endgenerate

   typedef enum logic {WAIT_SYNC, SCAN} state_t;

   state_t      state, state_nxt;
   logic        capture, frame_end, resync;
   logic        at_origin, at_last;
   logic [15:0] capture_data;

   assign at_origin = (x == 7'd0) && (y == 6'd0);
   assign at_last   = (x == X_LAST) && (y == Y_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_SYNC;
      else       state <= state_nxt;
   end

   // A strobe that lands with frame_begin on the final pixel is a clean frame end, not a resync.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      frame_end = 1'b0;
      resync    = 1'b0;
      case (state)
         WAIT_SYNC: begin
            if (frame_begin) state_nxt = SCAN;
         end
         SCAN: begin
            capture   = sample_pixel;
            frame_end = sample_pixel && at_last;
            resync    = frame_begin && !at_origin && !frame_end;
         end
         default: state_nxt = WAIT_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x <= 7'd0;
         y <= 6'd0;
      end else if (state == SCAN) begin
         if (frame_begin) begin
            x <= 7'd0;
            y <= 6'd0;
         end else if (sample_pixel) begin
            if (x == X_LAST) begin
               x <= 7'd0;
               y <= (y == Y_LAST) ? 6'd0 : y + 6'd1;
            end else begin
               x <= x + 7'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_data  <= 16'h0000;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         sync_lost   <= 1'b0;
      end else begin
         pixel_valid <= capture;
         frame_done  <= frame_end;
         if (capture)   pixel_data  <= capture_data;
         if (frame_end) frame_count <= frame_count + CNT_ONE;
         if (resync)    sync_lost   <= 1'b1;
      end
   end

`ifdef SCAN_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [BW-1:0] blink_cnt;

   assign capture_data = (blink_phase && screen_data == 16'hFFFF) ? 16'h0000 : screen_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_end) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= !blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end
`else
   assign capture_data = screen_data;
   assign blink_phase  = 1'b0;
`endif

endmodule

// File: tb/tb_oled_scan_sequencer.sv
// Directed test of oled_scan_sequencer: sync gating, raster stepping, frame end, resync, blink, reset.
module tb_oled_scan_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_begin = 1'b0;
   logic        sample_pixel = 1'b0;
   logic [15:0] screen_data;
   logic [6:0]  x;
   logic [5:0]  y;
   logic [15:0] pixel_data;
   logic        pixel_valid;
   logic        frame_done;
   logic [7:0]  frame_count;
   logic        blink_phase;
   logic        sync_lost;

   logic        const_mode = 1'b0;
   logic [15:0] const_data = 16'h0000;
   int          n_assert = 0;
   int          n_fail = 0;
   int          pv_cnt = 0;
   int          fd_cnt = 0;

`ifdef SCAN_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   always_comb screen_data = const_mode ? const_data : {3'b000, x, y};

   oled_scan_sequencer #(.BLINK_FRAMES(2)) dut (
      .clk(clk), .reset(reset), .frame_begin(frame_begin), .sample_pixel(sample_pixel),
      .screen_data(screen_data), .x(x), .y(y), .pixel_data(pixel_data),
      .pixel_valid(pixel_valid), .frame_done(frame_done), .frame_count(frame_count),
      .blink_phase(blink_phase), .sync_lost(sync_lost)
   );

   always @(posedge clk) begin
      #1;
      if (pixel_valid) pv_cnt++;
      if (frame_done)  fd_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample_pixel = 1'b1;
      end
      @(negedge clk);
      sample_pixel = 1'b0;
   endtask

   task automatic pulse_frame_begin();
      @(negedge clk);
      frame_begin = 1'b1;
      @(negedge clk);
      frame_begin = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      frame_begin = 1'b0;
      sample_pixel = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_x"}, 32'(x), 32'd0);
      check({tag, "_y"}, 32'(y), 32'd0);
      check({tag, "_pixel_data"}, 32'(pixel_data), 32'h0);
      check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
      check({tag, "_blink_phase"}, 32'(blink_phase), 32'd0);
      check({tag, "_sync_lost"}, 32'(sync_lost), 32'd0);
   endtask

   logic [15:0] blink_exp [6];
   logic        phase_exp [6];

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_reset_state("reset");
      reset = 1'b0;

      // 1: strobes while waiting for sync are ignored
      pv_cnt = 0;
      strobes(5);
      @(negedge clk);
      check("t1_pv_cnt", 32'(pv_cnt), 32'd0);
      check("t1_x", 32'(x), 32'd0);
      check("t1_y", 32'(y), 32'd0);

      // 2: row stepping and wrap with {x,y} pattern
      pulse_frame_begin();
      pv_cnt = 0;
      strobes(95);
      check("t2_x95", 32'(x), 32'd95);
      check("t2_y0", 32'(y), 32'd0);
      check("t2_pix_94_0", 32'(pixel_data), 32'h1780);
      strobes(1);
      check("t2_wrap_x", 32'(x), 32'd0);
      check("t2_wrap_y", 32'(y), 32'd1);
      check("t2_pix_95_0", 32'(pixel_data), 32'h17C0);
      strobes(1);
      check("t2_pv_cnt", 32'(pv_cnt), 32'd97);
      check("t2_pix_0_1", 32'(pixel_data), 32'h0001);
      check("t2_x1", 32'(x), 32'd1);
      check("t2_y1", 32'(y), 32'd1);

      // 3: full frame
      do_reset();
      pulse_frame_begin();
      fd_cnt = 0;
      strobes(6143);
      check("t3_no_early_done", 32'(fd_cnt), 32'd0);
      strobes(1);
      check("t3_frame_done", 32'(frame_done), 32'd1);
      check("t3_frame_count", 32'(frame_count), 32'd1);
      check("t3_x", 32'(x), 32'd0);
      check("t3_y", 32'(y), 32'd0);
      check("t3_sync_lost", 32'(sync_lost), 32'd0);
      @(negedge clk);
      check("t3_done_pulse", 32'(frame_done), 32'd0);
      check("t3_fd_cnt", 32'(fd_cnt), 32'd1);

      // 4: resync mid-frame, then frame_begin with the last strobe
      strobes(3 * 96 + 10);
      check("t4_x10", 32'(x), 32'd10);
      check("t4_y3", 32'(y), 32'd3);
      pulse_frame_begin();
      check("t4_resync_x", 32'(x), 32'd0);
      check("t4_resync_y", 32'(y), 32'd0);
      check("t4_sync_lost", 32'(sync_lost), 32'd1);
      check("t4_count_held", 32'(frame_count), 32'd1);
      strobes(6143);
      check("t4_x95", 32'(x), 32'd95);
      check("t4_y63", 32'(y), 32'd63);
      @(negedge clk);
      frame_begin = 1'b1;
      sample_pixel = 1'b1;
      @(negedge clk);
      frame_begin = 1'b0;
      sample_pixel = 1'b0;
      check("t4_both_done", 32'(frame_done), 32'd1);
      check("t4_both_valid", 32'(pixel_valid), 32'd1);
      check("t4_both_count", 32'(frame_count), 32'd2);
      check("t4_both_x", 32'(x), 32'd0);
      check("t4_both_y", 32'(y), 32'd0);
      check("t4_sync_sticky", 32'(sync_lost), 32'd1);

      // 6: reset mid-frame
      strobes(40);
      check("t6_x40", 32'(x), 32'd40);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("t6");
      reset = 1'b0;
      pv_cnt = 0;
      strobes(3);
      @(negedge clk);
      check("t6_wait_sync_x", 32'(x), 32'd0);
      check("t6_wait_sync_pv", 32'(pv_cnt), 32'd0);

      // 5: blink with BLINK_FRAMES=2
      blink_exp = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
      phase_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      const_mode = 1'b1;
      const_data = 16'hFFFF;
      pulse_frame_begin();
      for (int f = 0; f < 6; f++) begin
         strobes(6144);
         check($sformatf("t5_frame%0d_pix", f + 1), 32'(pixel_data),
               BLINK_ON ? 32'(blink_exp[f]) : 32'hFFFF);
         check($sformatf("t5_frame%0d_phase", f + 1), 32'(blink_phase),
               BLINK_ON ? 32'(phase_exp[f]) : 32'd0);
      end
      const_data = 16'hF800;
      strobes(6144);
      check("t5_red_unchanged", 32'(pixel_data), 32'hF800);
      check("t5_frame_count", 32'(frame_count), 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
